// File: rtl/axi_arbiter_2x1.sv
// axi_arbiter_2x1: two AXI requesters onto one downstream port; read and write paths arbitrate independently.
// Define AXI_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise m1 has fixed priority over m0.
module axi_arbiter_2x1 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LOCKW   = 2,
    parameter int AXILENW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m0_axi_arvalid,
    output logic               m0_axi_arready,
    input  logic [AW-1:0]      m0_axi_araddr,
    input  logic [3:0]         m0_axi_arcache,
    input  logic [2:0]         m0_axi_arprot,
    input  logic [LOCKW-1:0]   m0_axi_arlock,
    input  logic [1:0]         m0_axi_arburst,
    input  logic [AXILENW-1:0] m0_axi_arlen,
    input  logic [2:0]         m0_axi_arsize,
    input  logic               m0_axi_awvalid,
    output logic               m0_axi_awready,
    input  logic [AW-1:0]      m0_axi_awaddr,
    input  logic [3:0]         m0_axi_awcache,
    input  logic [2:0]         m0_axi_awprot,
    input  logic [LOCKW-1:0]   m0_axi_awlock,
    input  logic [1:0]         m0_axi_awburst,
    input  logic [AXILENW-1:0] m0_axi_awlen,
    input  logic [2:0]         m0_axi_awsize,
    input  logic               m0_axi_wvalid,
    output logic               m0_axi_wready,
    input  logic [DW-1:0]      m0_axi_wdata,
    input  logic [DW/8-1:0]    m0_axi_wstrb,
    input  logic               m0_axi_wlast,
    output logic               m0_axi_rvalid,
    input  logic               m0_axi_rready,
    output logic [DW-1:0]      m0_axi_rdata,
    output logic [1:0]         m0_axi_rresp,
    output logic               m0_axi_rlast,
    output logic               m0_axi_bvalid,
    input  logic               m0_axi_bready,
    output logic [1:0]         m0_axi_bresp,
    input  logic               m1_axi_arvalid,
    output logic               m1_axi_arready,
    input  logic [AW-1:0]      m1_axi_araddr,
    input  logic [3:0]         m1_axi_arcache,
    input  logic [2:0]         m1_axi_arprot,
    input  logic [LOCKW-1:0]   m1_axi_arlock,
    input  logic [1:0]         m1_axi_arburst,
    input  logic [AXILENW-1:0] m1_axi_arlen,
    input  logic [2:0]         m1_axi_arsize,
    input  logic               m1_axi_awvalid,
    output logic               m1_axi_awready,
    input  logic [AW-1:0]      m1_axi_awaddr,
    input  logic [3:0]         m1_axi_awcache,
    input  logic [2:0]         m1_axi_awprot,
    input  logic [LOCKW-1:0]   m1_axi_awlock,
    input  logic [1:0]         m1_axi_awburst,
    input  logic [AXILENW-1:0] m1_axi_awlen,
    input  logic [2:0]         m1_axi_awsize,
    input  logic               m1_axi_wvalid,
    output logic               m1_axi_wready,
    input  logic [DW-1:0]      m1_axi_wdata,
    input  logic [DW/8-1:0]    m1_axi_wstrb,
    input  logic               m1_axi_wlast,
    output logic               m1_axi_rvalid,
    input  logic               m1_axi_rready,
    output logic [DW-1:0]      m1_axi_rdata,
    output logic [1:0]         m1_axi_rresp,
    output logic               m1_axi_rlast,
    output logic               m1_axi_bvalid,
    input  logic               m1_axi_bready,
    output logic [1:0]         m1_axi_bresp,
    output logic               o_axi_arvalid,
    input  logic               o_axi_arready,
    output logic [AW-1:0]      o_axi_araddr,
    output logic [3:0]         o_axi_arcache,
    output logic [2:0]         o_axi_arprot,
    output logic [LOCKW-1:0]   o_axi_arlock,
    output logic [1:0]         o_axi_arburst,
    output logic [AXILENW-1:0] o_axi_arlen,
    output logic [2:0]         o_axi_arsize,
    output logic               o_axi_awvalid,
    input  logic               o_axi_awready,
    output logic [AW-1:0]      o_axi_awaddr,
    output logic [3:0]         o_axi_awcache,
    output logic [2:0]         o_axi_awprot,
    output logic [LOCKW-1:0]   o_axi_awlock,
    output logic [1:0]         o_axi_awburst,
    output logic [AXILENW-1:0] o_axi_awlen,
    output logic [2:0]         o_axi_awsize,
    output logic               o_axi_wvalid,
    input  logic               o_axi_wready,
    output logic [DW-1:0]      o_axi_wdata,
    output logic [DW/8-1:0]    o_axi_wstrb,
    output logic               o_axi_wlast,
    input  logic               o_axi_rvalid,
    output logic               o_axi_rready,
    input  logic [DW-1:0]      o_axi_rdata,
    input  logic [1:0]         o_axi_rresp,
    input  logic               o_axi_rlast,
    input  logic               o_axi_bvalid,
    output logic               o_axi_bready,
    input  logic [1:0]         o_axi_bresp
);
    localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0, W_BUSY = 2'd1, W_RESP = 2'd2;

    logic [1:0] r_state_q, r_state_d, w_state_q, w_state_d;
    logic       rgnt_q, rgnt_d, wgnt_q, wgnt_d;
    logic       aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic       r_req, w_req, r_pick, w_pick;
    logic       r_addr, r_data, w_busy, w_resp;
    logic       ar_fire, r_end, aw_fire, w_end, b_fire;

    assign r_req  = m0_axi_arvalid || m1_axi_arvalid;
    assign w_req  = m0_axi_awvalid || m1_axi_awvalid;
    assign r_addr = r_state_q == R_ADDR;
    assign r_data = r_state_q == R_DATA;
    assign w_busy = w_state_q == W_BUSY;
    assign w_resp = w_state_q == W_RESP;

`ifdef AXI_ARB_ROUND_ROBIN_EN
    // Pointers hold the last winner; on contention the other requester wins.
    logic rptr_q, wptr_q;
    assign r_pick = (m0_axi_arvalid && m1_axi_arvalid) ? !rptr_q : m1_axi_arvalid;
    assign w_pick = (m0_axi_awvalid && m1_axi_awvalid) ? !wptr_q : m1_axi_awvalid;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_q <= 1'b1;
            wptr_q <= 1'b1;
        end else begin
            if (r_state_q == R_IDLE && r_req) rptr_q <= r_pick;
            if (w_state_q == W_IDLE && w_req) wptr_q <= w_pick;
        end
    end
`else
    assign r_pick = m1_axi_arvalid;
    assign w_pick = m1_axi_awvalid;
`endif

    assign o_axi_arvalid  = r_addr && (rgnt_q ? m1_axi_arvalid : m0_axi_arvalid);
    assign o_axi_araddr   = rgnt_q ? m1_axi_araddr  : m0_axi_araddr;
    assign o_axi_arcache  = rgnt_q ? m1_axi_arcache : m0_axi_arcache;
    assign o_axi_arprot   = rgnt_q ? m1_axi_arprot  : m0_axi_arprot;
    assign o_axi_arlock   = rgnt_q ? m1_axi_arlock  : m0_axi_arlock;
    assign o_axi_arburst  = rgnt_q ? m1_axi_arburst : m0_axi_arburst;
    assign o_axi_arlen    = rgnt_q ? m1_axi_arlen   : m0_axi_arlen;
    assign o_axi_arsize   = rgnt_q ? m1_axi_arsize  : m0_axi_arsize;
    assign m0_axi_arready = r_addr && !rgnt_q && o_axi_arready;
    assign m1_axi_arready = r_addr &&  rgnt_q && o_axi_arready;
    assign o_axi_rready   = r_data && (rgnt_q ? m1_axi_rready : m0_axi_rready);
    assign m0_axi_rvalid  = r_data && !rgnt_q && o_axi_rvalid;
    assign m1_axi_rvalid  = r_data &&  rgnt_q && o_axi_rvalid;
    assign m0_axi_rdata   = o_axi_rdata;
    assign m1_axi_rdata   = o_axi_rdata;
    assign m0_axi_rresp   = o_axi_rresp;
    assign m1_axi_rresp   = o_axi_rresp;
    assign m0_axi_rlast   = o_axi_rlast;
    assign m1_axi_rlast   = o_axi_rlast;

    // AW and W each close independently; a finished channel is masked until the response.
    assign o_axi_awvalid  = w_busy && !aw_done_q && (wgnt_q ? m1_axi_awvalid : m0_axi_awvalid);
    assign o_axi_awaddr   = wgnt_q ? m1_axi_awaddr  : m0_axi_awaddr;
    assign o_axi_awcache  = wgnt_q ? m1_axi_awcache : m0_axi_awcache;
    assign o_axi_awprot   = wgnt_q ? m1_axi_awprot  : m0_axi_awprot;
    assign o_axi_awlock   = wgnt_q ? m1_axi_awlock  : m0_axi_awlock;
    assign o_axi_awburst  = wgnt_q ? m1_axi_awburst : m0_axi_awburst;
    assign o_axi_awlen    = wgnt_q ? m1_axi_awlen   : m0_axi_awlen;
    assign o_axi_awsize   = wgnt_q ? m1_axi_awsize  : m0_axi_awsize;
    assign m0_axi_awready = w_busy && !aw_done_q && !wgnt_q && o_axi_awready;
    assign m1_axi_awready = w_busy && !aw_done_q &&  wgnt_q && o_axi_awready;
    assign o_axi_wvalid   = w_busy && !w_done_q && (wgnt_q ? m1_axi_wvalid : m0_axi_wvalid);
    assign o_axi_wdata    = wgnt_q ? m1_axi_wdata : m0_axi_wdata;
    assign o_axi_wstrb    = wgnt_q ? m1_axi_wstrb : m0_axi_wstrb;
    assign o_axi_wlast    = wgnt_q ? m1_axi_wlast : m0_axi_wlast;
    assign m0_axi_wready  = w_busy && !w_done_q && !wgnt_q && o_axi_wready;
    assign m1_axi_wready  = w_busy && !w_done_q &&  wgnt_q && o_axi_wready;
    assign o_axi_bready   = w_resp && (wgnt_q ? m1_axi_bready : m0_axi_bready);
    assign m0_axi_bvalid  = w_resp && !wgnt_q && o_axi_bvalid;
    assign m1_axi_bvalid  = w_resp &&  wgnt_q && o_axi_bvalid;
    assign m0_axi_bresp   = o_axi_bresp;
    assign m1_axi_bresp   = o_axi_bresp;

    assign ar_fire = o_axi_arvalid && o_axi_arready;
    assign r_end   = o_axi_rvalid && o_axi_rready && o_axi_rlast;
    assign aw_fire = o_axi_awvalid && o_axi_awready;
    assign w_end   = o_axi_wvalid && o_axi_wready && o_axi_wlast;
    assign b_fire  = o_axi_bvalid && o_axi_bready;

    always_comb begin
        r_state_d = r_state_q;
        rgnt_d    = rgnt_q;
        if (r_state_q == R_IDLE && r_req) begin
            r_state_d = R_ADDR;
            rgnt_d    = r_pick;
        end else if (ar_fire) begin
            r_state_d = R_DATA;
        end else if (r_end) begin
            r_state_d = R_IDLE;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        wgnt_d    = wgnt_q;
        aw_done_d = aw_done_q || aw_fire;
        w_done_d  = w_done_q || w_end;
        if (w_state_q == W_IDLE && w_req) begin
            w_state_d = W_BUSY;
            wgnt_d    = w_pick;
        end else if (w_busy && aw_done_d && w_done_d) begin
            w_state_d = W_RESP;
        end else if (b_fire) begin
            w_state_d = W_IDLE;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
            rgnt_q    <= 1'b0;
            wgnt_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            rgnt_q    <= rgnt_d;
            wgnt_q    <= wgnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end
endmodule
